cnn_accel_ahb_regs: RTL and testbench

CNN_ACCEL_AHB_REGS -- requirements
Module: cnn_accel_ahb_regs

---
 rtl/cnn_accel_ahb_regs_pkg.sv | 69 ++++++
 rtl/cnn_accel_ahb_regs_start_fsm.sv | 50 +++++
 rtl/cnn_accel_ahb_regs.sv | 210 +++++++++++++++++++++
 tb/tb_cnn_accel_ahb_regs.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_accel_ahb_regs_pkg.sv
// Shared definitions for the CNN accelerator AHB register slice:
// register offsets, LAYER_CONFIG layout, AHB encodings and FSM states.
package cnn_accel_ahb_regs_pkg;

  localparam logic [5:0] OFF_FRAME_SIZE   = 6'h00;
  localparam logic [5:0] OFF_WIDTH_HEIGHT = 6'h04;
  localparam logic [5:0] OFF_DELAY_PARAMS = 6'h08;
  localparam logic [5:0] OFF_BASE_ADDRESS = 6'h0C;
  localparam logic [5:0] OFF_LAYER_CONFIG = 6'h10;
  localparam logic [5:0] OFF_LAYER_START  = 6'h14;
  localparam logic [5:0] OFF_LAYER_DONE   = 6'h18;
  localparam logic [5:0] OFF_IMAGE_BASE   = 6'h1C;
  localparam logic [5:0] OFF_IMAGE_LOAD   = 6'h20;

  localparam int WIDTH_LSB    = 0;
  localparam int HEIGHT_LSB   = 16;
  localparam int START_UP_LSB = 0;
  localparam int HSYNC_LSB    = 12;
  localparam int WEIGHT_LSB   = 0;
  localparam int WEIGHT_W     = 20;
  localparam int PARAM_LSB    = 20;
  localparam int PARAM_W      = 12;

  localparam int CFG_W        = 16;
  localparam int CFG_FIRST    = 0;
  localparam int CFG_LAST     = 1;
  localparam int CFG_CONV3X3  = 2;
  localparam int CFG_LAST_DUP = 3;
  localparam int CFG_IDX_LSB  = 4;
  localparam int CFG_IDX_W    = 4;
  localparam int CFG_BIAS_LSB = 8;
  localparam int CFG_BIAS_W   = 5;
  localparam int CFG_ACT_LSB  = 13;
  localparam int CFG_ACT_W    = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} layer_state_t;
  typedef enum logic [1:0] {D_IDLE = 2'd0, D_BUSY = 2'd1, D_DONE = 2'd2} dma_state_t;

  function automatic logic [CFG_W-1:0] pack_layer_config(input logic [CFG_W-1:0] word);
    logic [CFG_W-1:0] cfg;
    cfg = '0;
    cfg[CFG_FIRST]                    = word[CFG_FIRST];
    cfg[CFG_LAST]                     = word[CFG_LAST];
    cfg[CFG_CONV3X3]                  = word[CFG_CONV3X3];
    cfg[CFG_LAST_DUP]                 = word[CFG_LAST_DUP];
    cfg[CFG_IDX_LSB +: CFG_IDX_W]     = word[CFG_IDX_LSB +: CFG_IDX_W];
    cfg[CFG_BIAS_LSB +: CFG_BIAS_W]   = word[CFG_BIAS_LSB +: CFG_BIAS_W];
    cfg[CFG_ACT_LSB +: CFG_ACT_W]     = word[CFG_ACT_LSB +: CFG_ACT_W];
    return cfg;
  endfunction

  // Byte lanes touched by a transfer of the given HSIZE at HADDR[1:0].
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      3'd0:    lane_mask = 4'b0001 << addr;
      3'd1:    lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/cnn_accel_ahb_regs_start_fsm.sv
// Start/busy/done handshake FSM with a one-cycle start pulse; shared by
// the layer controller and the input-image DMA.
module cnn_accel_start_fsm
  import cnn_accel_ahb_regs_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       start_req,
  input  logic       done_evt,
  output logic       start_pulse,
  output logic [1:0] state
);

  layer_state_t state_q, state_d;
  logic         pulse_q, launch;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= launch;
    end
  end

  // A start in DONE takes priority over a coincident done event.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_req) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (done_evt) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_pulse = pulse_q;
    state       = state_q;
  end

endmodule

// File: rtl/cnn_accel_ahb_regs.sv
// AHB-Lite register slave for the CNN accelerator. Define CNN_ACCEL_REG_PROT_EN
// to reject config writes (0x00-0x10) with an ERROR response while a layer runs.
module cnn_accel_ahb_regs
  import cnn_accel_ahb_regs_pkg::*;
#(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int W_SIZE       = 12,
  parameter int W_FRAME_SIZE = 25
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [W_ADDR-1:0]       HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [W_DATA-1:0]       HWDATA,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [W_DATA-1:0]       HRDATA,
  output logic [W_FRAME_SIZE-1:0] o_frame_size,
  output logic [W_SIZE-1:0]       o_width,
  output logic [W_SIZE-1:0]       o_height,
  output logic [W_SIZE-1:0]       o_start_up_delay,
  output logic [W_SIZE-1:0]       o_hsync_delay,
  output logic [19:0]             o_base_addr_weight,
  output logic [11:0]             o_base_addr_param,
  output logic [15:0]             o_layer_config,
  output logic                    o_layer_start,
  input  logic                    i_layer_done,
  output logic [W_ADDR-1:0]       o_dma_base,
  output logic                    o_dma_start,
  input  logic                    i_dma_done
);

  logic                    trans_valid, accept, wr_en, prot_err, err_hold;
  logic                    dp_valid, dp_write;
  logic [3:0]              dp_idx, bytes;
  logic [1:0]              dp_lane, layer_raw, dma_raw;
  logic [2:0]              dp_size;
  logic [5:0]              dp_off;
  logic [W_DATA-1:0]       rd_word, bit_mask, merged;
  logic                    layer_start_req, dma_start_req;
  layer_state_t            layer_state;
  dma_state_t              dma_state;
  logic [W_FRAME_SIZE-1:0] frame_size;
  logic [W_SIZE-1:0]       width, height, start_up, hsync;
  logic [WEIGHT_W-1:0]     base_weight;
  logic [PARAM_W-1:0]      base_param;
  logic [CFG_W-1:0]        layer_config;
  logic [W_ADDR-1:0]       dma_base;
  logic                    unused_addr;

  assign unused_addr = &{1'b0, HADDR[W_ADDR-1:6]};

  always_comb begin
    trans_valid = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_valid = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_valid = 1'b0;
    endcase
  end

  assign accept = HSEL && HREADY && trans_valid;

  // Address-phase capture; an errored data phase is retired immediately.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_lane  <= '0;
      dp_size  <= '0;
    end else if (prot_err) begin
      dp_valid <= 1'b0;
    end else if (HREADY) begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= HWRITE;
        dp_idx   <= HADDR[5:2];
        dp_lane  <= HADDR[1:0];
        dp_size  <= HSIZE;
      end
    end
  end

  assign dp_off = {dp_idx, 2'b00};

  always_comb begin
    rd_word = '0;
    case (dp_off)
      OFF_FRAME_SIZE:   rd_word[W_FRAME_SIZE-1:0] = frame_size;
      OFF_WIDTH_HEIGHT: begin
        rd_word[WIDTH_LSB +: W_SIZE]  = width;
        rd_word[HEIGHT_LSB +: W_SIZE] = height;
      end
      OFF_DELAY_PARAMS: begin
        rd_word[START_UP_LSB +: W_SIZE] = start_up;
        rd_word[HSYNC_LSB +: W_SIZE]    = hsync;
      end
      OFF_BASE_ADDRESS: begin
        rd_word[WEIGHT_LSB +: WEIGHT_W] = base_weight;
        rd_word[PARAM_LSB +: PARAM_W]   = base_param;
      end
      OFF_LAYER_CONFIG: rd_word[CFG_W-1:0]  = layer_config;
      OFF_LAYER_START:  rd_word[0]          = (layer_state == RUN);
      OFF_LAYER_DONE:   rd_word[0]          = (layer_state == DONE);
      OFF_IMAGE_BASE:   rd_word[W_ADDR-1:0] = dma_base;
      OFF_IMAGE_LOAD:   rd_word[0]          = (dma_state == D_DONE);
      default:          rd_word             = '0;
    endcase
  end

  assign bytes = lane_mask(dp_size, dp_lane);

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < W_DATA / 8; i++) bit_mask[8*i +: 8] = {8{bytes[i]}};
  end

  // Partial writes merge new lanes into the current register contents.
  assign merged = (rd_word & ~bit_mask) | (HWDATA & bit_mask);

`ifdef CNN_ACCEL_REG_PROT_EN
  assign prot_err = dp_valid && dp_write && (dp_off <= OFF_LAYER_CONFIG) && (layer_state == RUN);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err_hold <= 1'b0;
    else        err_hold <= prot_err;
  end
`else
  assign prot_err = 1'b0;
  assign err_hold = 1'b0;
`endif

  assign wr_en     = dp_valid && dp_write && !prot_err;
  assign HREADYOUT = !prot_err;
  assign HRESP     = (prot_err || err_hold) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (dp_valid && !dp_write) ? rd_word : '0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      frame_size   <= '0;
      width        <= '0;
      height       <= '0;
      start_up     <= '0;
      hsync        <= '0;
      base_weight  <= '0;
      base_param   <= '0;
      layer_config <= '0;
      dma_base     <= '0;
    end else if (wr_en) begin
      case (dp_off)
        OFF_FRAME_SIZE:   frame_size <= merged[W_FRAME_SIZE-1:0];
        OFF_WIDTH_HEIGHT: begin
          width  <= merged[WIDTH_LSB +: W_SIZE];
          height <= merged[HEIGHT_LSB +: W_SIZE];
        end
        OFF_DELAY_PARAMS: begin
          start_up <= merged[START_UP_LSB +: W_SIZE];
          hsync    <= merged[HSYNC_LSB +: W_SIZE];
        end
        OFF_BASE_ADDRESS: begin
          base_weight <= merged[WEIGHT_LSB +: WEIGHT_W];
          base_param  <= merged[PARAM_LSB +: PARAM_W];
        end
        OFF_LAYER_CONFIG: layer_config <= pack_layer_config(merged[CFG_W-1:0]);
        OFF_IMAGE_BASE:   dma_base     <= merged[W_ADDR-1:0];
        default: ;
      endcase
    end
  end

  assign layer_start_req = wr_en && (dp_off == OFF_LAYER_START) && bytes[0] && HWDATA[0];
  assign dma_start_req   = wr_en && (dp_off == OFF_IMAGE_LOAD) && bytes[0] && HWDATA[0];

  cnn_accel_start_fsm u_layer_fsm (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .start_req   (layer_start_req),
    .done_evt    (i_layer_done),
    .start_pulse (o_layer_start),
    .state       (layer_raw)
  );

  cnn_accel_start_fsm u_dma_fsm (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .start_req   (dma_start_req),
    .done_evt    (i_dma_done),
    .start_pulse (o_dma_start),
    .state       (dma_raw)
  );

  assign layer_state = layer_state_t'(layer_raw);
  assign dma_state   = dma_state_t'(dma_raw);

  assign o_frame_size       = frame_size;
  assign o_width            = width;
  assign o_height           = height;
  assign o_start_up_delay   = start_up;
  assign o_hsync_delay      = hsync;
  assign o_base_addr_weight = base_weight;
  assign o_base_addr_param  = base_param;
  assign o_layer_config     = layer_config;
  assign o_dma_base         = dma_base;

endmodule

// File: tb/tb_cnn_accel_ahb_regs.sv
// Directed self-checking bench for cnn_accel_ahb_regs; expectations follow
// CNN_ACCEL_REG_PROT_EN when it is defined for the build.
module tb_cnn_accel_ahb_regs;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [24:0] o_frame_size;
  logic [11:0] o_width, o_height, o_start_up_delay, o_hsync_delay;
  logic [19:0] o_base_addr_weight;
  logic [11:0] o_base_addr_param;
  logic [15:0] o_layer_config;
  logic        o_layer_start;
  logic        i_layer_done = 1'b0;
  logic [31:0] o_dma_base;
  logic        o_dma_start;
  logic        i_dma_done = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          layer_pulses = 0;
  int          dma_pulses = 0;
  int          pulse_base;
  logic [31:0] rd_data;
  logic        rdy1, resp1, rdy2, resp2;
  logic        exp_rdy1, exp_resp1, exp_resp2;
  logic [15:0] exp_cfg;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  cnn_accel_ahb_regs dut (
    .HCLK               (HCLK),
    .HRESET             (HRESET),
    .HSEL               (HSEL),
    .HADDR              (HADDR),
    .HTRANS             (HTRANS),
    .HWRITE             (HWRITE),
    .HSIZE              (HSIZE),
    .HWDATA             (HWDATA),
    .HREADY             (HREADY),
    .HREADYOUT          (HREADYOUT),
    .HRESP              (HRESP),
    .HRDATA             (HRDATA),
    .o_frame_size       (o_frame_size),
    .o_width            (o_width),
    .o_height           (o_height),
    .o_start_up_delay   (o_start_up_delay),
    .o_hsync_delay      (o_hsync_delay),
    .o_base_addr_weight (o_base_addr_weight),
    .o_base_addr_param  (o_base_addr_param),
    .o_layer_config     (o_layer_config),
    .o_layer_start      (o_layer_start),
    .i_layer_done       (i_layer_done),
    .o_dma_base         (o_dma_base),
    .o_dma_start        (o_dma_start),
    .i_dma_done         (i_dma_done)
  );

  always @(posedge HCLK) begin
    if (o_layer_start) layer_pulses <= layer_pulses + 1;
    if (o_dma_start)   dma_pulses   <= dma_pulses + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  // One AHB transfer started at a negedge; samples the data-phase response
  // and the following cycle, and absorbs the extra cycle of an ERROR response.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                               input logic [2:0] size);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR  = {24'h0, addr};
    HSIZE  = size;
    tick();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = wr ? wdata : 32'h0;
    #1;
    rd_data = HRDATA;
    rdy1    = HREADYOUT;
    resp1   = HRESP;
    @(posedge HCLK);
    @(negedge HCLK);
    rdy2  = HREADYOUT;
    resp2 = HRESP;
    if (!rdy1) tick();
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [31:0] wdata);
    applyStimulus(1'b1, addr, wdata, 3'd2);
  endtask

  task automatic busRead(input string tag, input logic [7:0] addr, input logic [31:0] expected);
    applyStimulus(1'b0, addr, 32'h0, 3'd2);
    checkOutput(tag, rd_data, expected);
  endtask

  task automatic pulseLayerDone();
    i_layer_done = 1'b1;
    tick();
    i_layer_done = 1'b0;
  endtask

  task automatic pulseDmaDone();
    i_dma_done = 1'b1;
    tick();
    i_dma_done = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge HCLK);
    checkOutput("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    checkOutput("rst_hresp", 32'(HRESP), 32'h0);
    checkOutput("rst_hrdata", HRDATA, 32'h0);
    checkOutput("rst_frame", 32'(o_frame_size), 32'h0);
    checkOutput("rst_layer_start", 32'(o_layer_start), 32'h0);
    checkOutput("rst_dma_start", 32'(o_dma_start), 32'h0);
    HRESET = 1'b0;
    tick();

    pulseLayerDone();
    busRead("idle_done_ignored", 8'h18, 32'h0);
    pulseDmaDone();
    busRead("dma_idle_done_ignored", 8'h20, 32'h0);

    busWrite(8'h00, 32'h0000_4000);
    checkOutput("frame_size", 32'(o_frame_size), 32'h4000);
    busWrite(8'h04, 32'h0080_0080);
    checkOutput("width", 32'(o_width), 32'd128);
    checkOutput("height", 32'(o_height), 32'd128);
    busRead("rd_frame", 8'h00, 32'h0000_4000);
    busRead("rd_wh", 8'h04, 32'h0080_0080);
    checkOutput("rd_okay", 32'(resp1), 32'h0);

    busWrite(8'h08, 32'h000A_00C8);
    checkOutput("start_up", 32'(o_start_up_delay), 32'd200);
    checkOutput("hsync", 32'(o_hsync_delay), 32'd160);
    busRead("rd_delay", 8'h08, 32'h000A_00C8);

    busWrite(8'h0C, 32'hABC1_2345);
    checkOutput("base_weight", 32'(o_base_addr_weight), 32'h1_2345);
    checkOutput("base_param", 32'(o_base_addr_param), 32'hABC);

    busWrite(8'h10, 32'hFFFF_FFFF);
    busRead("rd_cfg_unused_zero", 8'h10, 32'h0000_FFFF);
    busWrite(8'h10, 32'h0000_2A35);
    checkOutput("layer_config", 32'(o_layer_config), 32'h2A35);

    applyStimulus(1'b1, 8'h01, 32'hAAAA_55AA, 3'd0);
    checkOutput("byte_write", 32'(o_frame_size), 32'h5500);
    applyStimulus(1'b1, 8'h06, 32'h0040_BBBB, 3'd1);
    checkOutput("half_write_height", 32'(o_height), 32'd64);
    checkOutput("half_write_width", 32'(o_width), 32'd128);

    busRead("unmapped_24", 8'h24, 32'h0);
    checkOutput("unmapped_okay", 32'(resp1), 32'h0);
    busRead("unmapped_3c", 8'h3C, 32'h0);

    busRead("busy_idle", 8'h14, 32'h0);
    pulse_base = layer_pulses;
    busWrite(8'h14, 32'h0000_0002);
    tick();
    checkOutput("bit0_zero_no_pulse", 32'(layer_pulses - pulse_base), 32'h0);
    busRead("bit0_zero_still_idle", 8'h14, 32'h0);

    busWrite(8'h14, 32'h0000_0001);
    checkOutput("layer_pulse_high", 32'(o_layer_start), 32'h1);
    tick();
    checkOutput("layer_pulse_low", 32'(o_layer_start), 32'h0);
    checkOutput("layer_pulse_count", 32'(layer_pulses - pulse_base), 32'h1);
    busRead("busy_run", 8'h14, 32'h1);
    busRead("done_in_run", 8'h18, 32'h0);

    busWrite(8'h14, 32'h0000_0001);
    tick();
    checkOutput("run_restart_ignored", 32'(layer_pulses - pulse_base), 32'h1);

`ifdef CNN_ACCEL_REG_PROT_EN
    exp_rdy1  = 1'b0;
    exp_resp1 = 1'b1;
    exp_resp2 = 1'b1;
    exp_cfg   = 16'h2A35;
`else
    exp_rdy1  = 1'b1;
    exp_resp1 = 1'b0;
    exp_resp2 = 1'b0;
    exp_cfg   = 16'h1111;
`endif
    busWrite(8'h10, 32'h0000_1111);
    checkOutput("prot_rdy_cycle1", 32'(rdy1), 32'(exp_rdy1));
    checkOutput("prot_resp_cycle1", 32'(resp1), 32'(exp_resp1));
    checkOutput("prot_rdy_cycle2", 32'(rdy2), 32'h1);
    checkOutput("prot_resp_cycle2", 32'(resp2), 32'(exp_resp2));
    checkOutput("prot_cfg", 32'(o_layer_config), 32'(exp_cfg));
    checkOutput("prot_resp_after", 32'(HRESP), 32'h0);

    pulseLayerDone();
    busRead("done_after_done", 8'h18, 32'h1);
    busRead("busy_after_done", 8'h14, 32'h0);
    pulseLayerDone();
    busRead("done_held", 8'h18, 32'h1);

    busWrite(8'h14, 32'h0000_0001);
    busRead("done_cleared_by_start", 8'h18, 32'h0);
    busRead("busy_restart", 8'h14, 32'h1);
    pulseLayerDone();

    i_layer_done = 1'b1;
    busWrite(8'h14, 32'h0000_0001);
    i_layer_done = 1'b0;
    busRead("start_wins_over_done", 8'h14, 32'h1);

    busWrite(8'h1C, 32'h8000_1000);
    checkOutput("dma_base", o_dma_base, 32'h8000_1000);
    busRead("rd_dma_base", 8'h1C, 32'h8000_1000);
    pulse_base = dma_pulses;
    busWrite(8'h20, 32'h0000_0001);
    checkOutput("dma_pulse_high", 32'(o_dma_start), 32'h1);
    tick();
    checkOutput("dma_pulse_low", 32'(o_dma_start), 32'h0);
    checkOutput("dma_pulse_count", 32'(dma_pulses - pulse_base), 32'h1);
    busRead("dma_busy_not_done", 8'h20, 32'h0);
    pulseDmaDone();
    busRead("dma_done", 8'h20, 32'h1);

    #2 HRESET = 1'b1;
    #1;
    checkOutput("midrun_rst_frame", 32'(o_frame_size), 32'h0);
    checkOutput("midrun_rst_cfg", 32'(o_layer_config), 32'h0);
    checkOutput("midrun_rst_dma_base", o_dma_base, 32'h0);
    checkOutput("midrun_rst_layer_start", 32'(o_layer_start), 32'h0);
    checkOutput("midrun_rst_hreadyout", 32'(HREADYOUT), 32'h1);
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();
    busRead("midrun_rst_busy", 8'h14, 32'h0);
    busRead("midrun_rst_dma_done", 8'h20, 32'h0);
    pulseLayerDone();
    busRead("midrun_rst_done_ignored", 8'h18, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
